// File: rtl/sram_pkg.sv
// Shared types and default parameters for the asynchronous SRAM controller.
package sram_pkg;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_ADDR_W   = 18;
  localparam int unsigned DEF_WAIT_CYC = 1;
  localparam int unsigned WAIT_CYC_MAX = 15;
  localparam int unsigned CNT_W        = $clog2(WAIT_CYC_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/sram_io.sv
// SRAM data-bus pad logic: tristate write driver and registered read capture.
module sram_io
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drive,
  input  logic [DATA_W-1:0] wdata,
  input  logic              capture_c,
  inout  wire  [DATA_W-1:0] dq,
  output logic [DATA_W-1:0] rdata
);

  assign dq = drive ? wdata : {DATA_W{1'bz}};

  // Read data is only refreshed by a read capture, so writes never disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (capture_c) begin
      rdata <= dq;
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Single-access asynchronous SRAM controller: IDLE -> ACCESS (WAIT_CYC+1 cycles) -> DONE.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iREQ,
  input  logic                  iWE,
  input  logic [ADDR_W-1:0]     iADDR,
  input  logic [DATA_W-1:0]     iDATA,
  input  logic [DATA_W/8-1:0]   iBE_N,
  output logic [DATA_W-1:0]     oDATA,
  output logic                  oACK,
  output logic                  oBUSY,
  inout  wire  [DATA_W-1:0]     SRAM_DQ,
  output logic [ADDR_W-1:0]     SRAM_ADDR,
  output logic [DATA_W/8-1:0]   SRAM_BE_N,
  output logic                  SRAM_WE_N,
  output logic                  SRAM_OE_N,
  output logic                  SRAM_CE_N
);

  localparam int unsigned BE_W = DATA_W / 8;

  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("sram_ctrl: DATA_W must be a multiple of 8");
  end
  if (WAIT_CYC > WAIT_CYC_MAX) begin : g_bad_wait_cyc
    $error("sram_ctrl: WAIT_CYC out of range");
  end

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              wr;
  logic [DATA_W-1:0] wdata;
  logic              dq_oe;
  logic              capture_c;

  // Read data is sampled on the edge that closes the last ACCESS cycle.
  assign capture_c = (state == ST_ACCESS) && (cnt == '0) && !wr;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      wr        <= 1'b0;
      wdata     <= '0;
      dq_oe     <= 1'b0;
      oACK      <= 1'b0;
      oBUSY     <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_BE_N <= '1;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_CE_N <= 1'b1;
    end else begin
      oACK <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iREQ) begin
            state     <= ST_ACCESS;
            cnt       <= CNT_W'(WAIT_CYC);
            wr        <= iWE;
            wdata     <= iDATA;
            dq_oe     <= iWE;
            oBUSY     <= 1'b1;
            SRAM_ADDR <= iADDR;
            SRAM_BE_N <= iBE_N;
            SRAM_CE_N <= 1'b0;
            SRAM_OE_N <= iWE;
            SRAM_WE_N <= !iWE;
          end
        end
        ST_ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // Writes keep CE_N, byte strobes and DQ for hold time past WE_N rising.
            state     <= ST_DONE;
            oACK      <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            if (!wr) begin
              SRAM_CE_N <= 1'b1;
              SRAM_BE_N <= '1;
            end
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          oBUSY     <= 1'b0;
          dq_oe     <= 1'b0;
          SRAM_CE_N <= 1'b1;
          SRAM_OE_N <= 1'b1;
          SRAM_WE_N <= 1'b1;
          SRAM_BE_N <= {BE_W{1'b1}};
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  sram_io #(
    .DATA_W (DATA_W)
  ) u_io (
    .clk       (iCLK),
    .rst       (iRST),
    .drive     (dq_oe),
    .wdata     (wdata),
    .capture_c (capture_c),
    .dq        (SRAM_DQ),
    .rdata     (oDATA)
  );

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: three instances (WAIT_CYC 1, 0, 15), each with a behavioural SRAM.
module tb_sram_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 18;
  localparam int unsigned BW = 2;
  localparam int NU = 3;

  typedef struct packed {
    logic          ce_n;
    logic          oe_n;
    logic          we_n;
    logic [BW-1:0] be_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] od;
    logic          ack;
    logic          busy;
    logic [DW-1:0] dq;
  } obs_t;

  typedef struct {
    int            u;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] be;
    logic [DW-1:0] exp_od;
  } vec_t;

  logic clk, rst;
  logic iwe;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic [BW-1:0] ibe;
  logic req0, req1, req2;
  logic ack0, ack1, ack2, busy0, busy1, busy2;
  logic ce_n0, ce_n1, ce_n2, oe_n0, oe_n1, oe_n2, we_n0, we_n1, we_n2;
  logic [BW-1:0] be0, be1, be2;
  logic [AW-1:0] sa0, sa1, sa2;
  logic [DW-1:0] od0, od1, od2;
  wire  [DW-1:0] dq0, dq1, dq2;
  logic [DW-1:0] mem0 [256];
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem2 [256];

  logic [DW-1:0] ref_mem [NU][256];
  logic [DW-1:0] ref_od [NU];
  int vectors = 0;
  int miscompares = 0;
  logic mon_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYC(1)) dut0 (
    .iCLK(clk), .iRST(rst), .iREQ(req0), .iWE(iwe), .iADDR(iaddr), .iDATA(idata), .iBE_N(ibe),
    .oDATA(od0), .oACK(ack0), .oBUSY(busy0), .SRAM_DQ(dq0), .SRAM_ADDR(sa0), .SRAM_BE_N(be0),
    .SRAM_WE_N(we_n0), .SRAM_OE_N(oe_n0), .SRAM_CE_N(ce_n0));
  sram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYC(0)) dut1 (
    .iCLK(clk), .iRST(rst), .iREQ(req1), .iWE(iwe), .iADDR(iaddr), .iDATA(idata), .iBE_N(ibe),
    .oDATA(od1), .oACK(ack1), .oBUSY(busy1), .SRAM_DQ(dq1), .SRAM_ADDR(sa1), .SRAM_BE_N(be1),
    .SRAM_WE_N(we_n1), .SRAM_OE_N(oe_n1), .SRAM_CE_N(ce_n1));
  sram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYC(15)) dut2 (
    .iCLK(clk), .iRST(rst), .iREQ(req2), .iWE(iwe), .iADDR(iaddr), .iDATA(idata), .iBE_N(ibe),
    .oDATA(od2), .oACK(ack2), .oBUSY(busy2), .SRAM_DQ(dq2), .SRAM_ADDR(sa2), .SRAM_BE_N(be2),
    .SRAM_WE_N(we_n2), .SRAM_OE_N(oe_n2), .SRAM_CE_N(ce_n2));

  // Async SRAMs: drive on CE&OE (read), latch enabled lanes on WE_N rising.
  pulldown pd0 (dq0);
  pulldown pd1 (dq1);
  pulldown pd2 (dq2);
  assign dq0 = (!ce_n0 && !oe_n0 && we_n0) ? mem0[sa0[7:0]] : 16'hzzzz;
  assign dq1 = (!ce_n1 && !oe_n1 && we_n1) ? mem1[sa1[7:0]] : 16'hzzzz;
  assign dq2 = (!ce_n2 && !oe_n2 && we_n2) ? mem2[sa2[7:0]] : 16'hzzzz;

  always @(posedge we_n0) if (!ce_n0) begin
    if (!be0[0]) mem0[sa0[7:0]][7:0]  <= dq0[7:0];
    if (!be0[1]) mem0[sa0[7:0]][15:8] <= dq0[15:8];
  end
  always @(posedge we_n1) if (!ce_n1) begin
    if (!be1[0]) mem1[sa1[7:0]][7:0]  <= dq1[7:0];
    if (!be1[1]) mem1[sa1[7:0]][15:8] <= dq1[15:8];
  end
  always @(posedge we_n2) if (!ce_n2) begin
    if (!be2[0]) mem2[sa2[7:0]][7:0]  <= dq2[7:0];
    if (!be2[1]) mem2[sa2[7:0]][15:8] <= dq2[15:8];
  end

  function automatic int wait_of(input int u);
    case (u)
      0:       return 1;
      1:       return 0;
      default: return 15;
    endcase
  endfunction

  function automatic obs_t obs(input int u);
    obs_t o;
    case (u)
      0: begin
        o.ce_n = ce_n0; o.oe_n = oe_n0; o.we_n = we_n0; o.be_n = be0; o.addr = sa0;
        o.od = od0; o.ack = ack0; o.busy = busy0; o.dq = dq0;
      end
      1: begin
        o.ce_n = ce_n1; o.oe_n = oe_n1; o.we_n = we_n1; o.be_n = be1; o.addr = sa1;
        o.od = od1; o.ack = ack1; o.busy = busy1; o.dq = dq1;
      end
      default: begin
        o.ce_n = ce_n2; o.oe_n = oe_n2; o.we_n = we_n2; o.be_n = be2; o.addr = sa2;
        o.od = od2; o.ack = ack2; o.busy = busy2; o.dq = dq2;
      end
    endcase
    return o;
  endfunction

  function automatic logic [DW-1:0] sram_word(input int u);
    case (u)
      0:       return mem0[sa0[7:0]];
      1:       return mem1[sa1[7:0]];
      default: return mem2[sa2[7:0]];
    endcase
  endfunction

  task automatic set_req(input int u, input logic v);
    case (u)
      0:       req0 = v;
      1:       req1 = v;
      default: req2 = v;
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: byte-merged memory image and the last read result per instance.
  task automatic ref_apply(input int u, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] be);
    if (w) begin
      for (int k = 0; k < BW; k++)
        if (!be[k]) ref_mem[u][a[7:0]][k*8 +: 8] = d[k*8 +: 8];
    end else begin
      ref_od[u] = ref_mem[u][a[7:0]];
    end
  endtask

  task automatic check_idle(input int u, input string tag, input logic [AW-1:0] a);
    obs_t o;
    o = obs(u);
    chk({tag, " ack"},  32'(o.ack), 32'd0);
    chk({tag, " busy"}, 32'(o.busy), 32'd0);
    chk({tag, " ce_n"}, 32'(o.ce_n), 32'd1);
    chk({tag, " oe_n"}, 32'(o.oe_n), 32'd1);
    chk({tag, " we_n"}, 32'(o.we_n), 32'd1);
    chk({tag, " be_n"}, 32'(o.be_n), 32'd3);
    chk({tag, " addr"}, 32'(o.addr), 32'(a));
    chk({tag, " dq"},   32'(o.dq), 32'd0);
    chk({tag, " odata"}, 32'(o.od), 32'(ref_od[u]));
  endtask

  // One complete access, checking every bus cycle, the latency and the return to IDLE.
  task automatic access(input int u, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be);
    obs_t o;
    int n;
    bit seen;
    iwe = w; iaddr = a; idata = d; ibe = be;
    set_req(u, 1'b1);
    n = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) set_req(u, 1'b0);
      o = obs(u);
      if (o.ack) begin
        seen = 1'b1;
      end else begin
        chk("acc busy", 32'(o.busy), 32'd1);
        chk("acc ce_n", 32'(o.ce_n), 32'd0);
        chk("acc oe_n", 32'(o.oe_n), 32'(w));
        chk("acc we_n", 32'(o.we_n), 32'(!w));
        chk("acc be_n", 32'(o.be_n), 32'(be));
        chk("acc addr", 32'(o.addr), 32'(a));
        if (w) chk("acc dq", 32'(o.dq), 32'(d));
      end
    end
    chk("latency", 32'(n), 32'(wait_of(u) + 2));
    ref_apply(u, w, a, d, be);
    if (seen) begin
      chk("done busy", 32'(o.busy), 32'd1);
      chk("done oe_n", 32'(o.oe_n), 32'd1);
      chk("done we_n", 32'(o.we_n), 32'd1);
      chk("done ce_n", 32'(o.ce_n), 32'(!w));
      if (w) chk("done dq hold", 32'(o.dq), 32'(d));
      chk("done odata", 32'(o.od), 32'(ref_od[u]));
    end
    @(posedge clk); #1;
    check_idle(u, "post", a);
  endtask

  // Bus monitor: DQ must never be driven by the controller while OE_N is low.
  always @(negedge clk) begin
    obs_t o;
    if (mon_en) begin
      for (int u = 0; u < NU; u++) begin
        o = obs(u);
        if (!o.oe_n) begin
          chk("mon we_n with oe_n", 32'(o.we_n), 32'd1);
          if (!o.ce_n) chk("mon dq contention", 32'(o.dq), 32'(sram_word(u)));
        end
        if (o.ce_n && o.we_n) chk("mon dq float", 32'(o.dq), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [13];
    obs_t o;
    int n, first, acks;
    logic w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] be;

    tbl[0]  = '{0, 1'b1, 18'h10, 16'hA5C3, 2'b00, 16'h0000};
    tbl[1]  = '{0, 1'b0, 18'h10, 16'h0000, 2'b00, 16'hA5C3};
    tbl[2]  = '{0, 1'b1, 18'h20, 16'h1234, 2'b00, 16'hA5C3};
    tbl[3]  = '{0, 1'b1, 18'h20, 16'hABCD, 2'b10, 16'hA5C3};
    tbl[4]  = '{0, 1'b0, 18'h20, 16'h0000, 2'b00, 16'h12CD};
    tbl[5]  = '{1, 1'b1, 18'h30, 16'hBEEF, 2'b00, 16'h0000};
    tbl[6]  = '{1, 1'b0, 18'h30, 16'h0000, 2'b00, 16'hBEEF};
    tbl[7]  = '{2, 1'b1, 18'h31, 16'h5A5A, 2'b00, 16'h0000};
    tbl[8]  = '{2, 1'b1, 18'h31, 16'hC3FF, 2'b01, 16'h0000};
    tbl[9]  = '{2, 1'b0, 18'h31, 16'h0000, 2'b00, 16'hC35A};
    tbl[10] = '{0, 1'b1, 18'h40, 16'h1111, 2'b00, 16'h12CD};
    tbl[11] = '{0, 1'b1, 18'h40, 16'hFFFF, 2'b11, 16'h12CD};
    tbl[12] = '{0, 1'b0, 18'h40, 16'h0000, 2'b00, 16'h1111};

    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
    iwe = 1'b0; iaddr = '0; idata = '0; ibe = '1;
    for (int u = 0; u < NU; u++) ref_od[u] = '0;
    #1 rst = 1'b1;
    #1;
    for (int u = 0; u < NU; u++) check_idle(u, "reset", 18'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 13; i++) begin
      access(tbl[i].u, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be);
      chk($sformatf("table[%0d] odata", i), 32'(obs(tbl[i].u).od), 32'(tbl[i].exp_od));
    end

    // Requests raised during ACCESS/DONE must be ignored.
    iwe = 1'b0; iaddr = 18'h31; ibe = 2'b00;
    set_req(2, 1'b1);
    n = 0; first = 0; acks = 0;
    while (n < 40 && first == 0) begin
      @(posedge clk); #1;
      n++;
      if (obs(2).ack) begin
        first = n; acks++; set_req(2, 1'b0);
      end else begin
        set_req(2, logic'(n[0]));
      end
    end
    set_req(2, 1'b0);
    ref_apply(2, 1'b0, 18'h31, 16'h0, 2'b00);
    chk("pulse latency", 32'(first), 32'd17);
    repeat (10) begin
      @(posedge clk); #1;
      if (obs(2).ack) acks++;
      chk("pulse busy", 32'(obs(2).busy), 32'd0);
    end
    chk("pulse ack count", 32'(acks), 32'd1);
    chk("pulse odata", 32'(obs(2).od), 32'h0000C35A);

    // Randomized traffic: prefill 16 words per instance, then mixed byte-lane reads/writes.
    for (int u = 0; u < NU; u++) begin
      for (int i = 0; i < 16; i++)
        access(u, 1'b1, AW'(i), DW'($urandom_range(1, 65535)), 2'b00);
      for (int i = 0; i < 30; i++) begin
        w  = 1'($urandom_range(0, 1));
        a  = AW'($urandom_range(0, 15));
        d  = DW'($urandom_range(1, 65535));
        be = BW'($urandom_range(0, 3));
        access(u, w, a, d, be);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end

    // Reset in the middle of a write ACCESS aborts it with no acknowledge.
    iwe = 1'b1; iaddr = 18'hFF; idata = 16'h7777; ibe = 2'b00;
    set_req(0, 1'b1);
    @(posedge clk); #1;
    set_req(0, 1'b0);
    chk("abort pre we_n", 32'(obs(0).we_n), 32'd0);
    #2 rst = 1'b1;
    #1;
    for (int u = 0; u < NU; u++) ref_od[u] = '0;
    o = obs(0);
    chk("abort we_n", 32'(o.we_n), 32'd1);
    chk("abort ce_n", 32'(o.ce_n), 32'd1);
    chk("abort dq", 32'(o.dq), 32'd0);
    for (int u = 0; u < NU; u++) check_idle(u, "abort", 18'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    acks = 0;
    repeat (20) begin
      @(posedge clk); #1;
      for (int u = 0; u < NU; u++) if (obs(u).ack || obs(u).busy) acks++;
    end
    chk("abort no ack", 32'(acks), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
